uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- Downstream consumer of the UART receive path. Takes the byte stream from uart_controller (rx_done/rx_data) and parses line-based ASCII commands.
- Generates control pulses for the watch/sensor datapath: a report request, which drives the start input of the sender block, run toggle, clear, and a time-set with validated hour/min/sec.
- Purely sequential parser. One byte is consumed per rx_done pulse.

Parameters:
- TIMEOUT_CYC, 1_000_000: idle cycles allowed mid-command before abort. Used only when CMD_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_done  in  1  one-cycle strobe; rx_data valid in that cycle
- rx_data  in  8  received byte
- o_send_req  out  1  one-cycle pulse: request one status report
- o_run_toggle  out  1  one-cycle pulse: toggle stopwatch run/stop
- o_clear  out  1  one-cycle pulse: clear stopwatch
- o_set_time  out  1  one-cycle pulse: o_set_hour/min/sec newly valid
- o_set_hour  out  6  hour to load, 0..23
- o_set_min  out  6  minute to load, 0..59
- o_set_sec  out  6  second to load, 0..59
- o_cmd_err  out  1  one-cycle pulse: malformed or out-of-range command
- o_busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port reset. On reset all outputs are 0, state is IDLE, and the digit buffer and counters are cleared. Reset asserted mid-command aborts the command; no pulse is issued.
- All outputs are registered. Each pulse is asserted exactly in the cycle after the rx_done cycle that completes or invalidates the command.
- Byte handling:
  - '\r' (0x0D) is ignored in every state.
  - Letters are case-insensitive ('s'/'S', etc.).
  - Back-to-back rx_done on consecutive cycles must be handled.
- States:
  - IDLE:
    - 'S'/'R'/'C' -> WAIT_EOL, command latched.
    - 'T' -> TIME_DIG, digit count = 0.
    - '\n' -> stay (empty line, no error).
    - Any other byte -> o_cmd_err, go to FLUSH.
  - WAIT_EOL:
    - '\n' -> pulse the latched command output (S->o_send_req, R->o_run_toggle, C->o_clear), go to IDLE.
    - Any other byte -> o_cmd_err, go to FLUSH.
  - TIME_DIG:
    - '0'..'9' -> store 4-bit digit at index cnt and increment cnt. When cnt reaches 6, go to TIME_EOL.
    - '\n' with fewer than 6 digits -> o_cmd_err, go to IDLE.
    - Any other byte -> o_cmd_err, go to FLUSH.
  - TIME_EOL:
    - '\n' -> hour = d0*10+d1, min = d2*10+d3, sec = d4*10+d5 (7-bit intermediate).
      - If hour<=23, min<=59 and sec<=59: load o_set_*, pulse o_set_time.
      - Otherwise: pulse o_cmd_err and leave o_set_* unchanged.
      - Either way, go to IDLE.
    - Any other byte -> o_cmd_err, go to FLUSH.
  - FLUSH: discard bytes until '\n', then go to IDLE. No further o_cmd_err pulses.
- o_set_hour/min/sec hold their last valid values between set commands.
- At most one output pulse per rx_done.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined:
  - A counter is cleared on every rx_done and in IDLE, and increments otherwise.
  - On reaching TIMEOUT_CYC-1 in any non-IDLE state: go to IDLE, clear the digit buffer, and pulse o_cmd_err. In FLUSH, go to IDLE silently with no error.
  - An rx_done arriving in the expiry cycle has priority: the byte is processed and the counter clears.
- Undefined: no counter; the parser waits indefinitely. TIMEOUT_CYC is unused.

Decomposition:
- Package uart_cmd_pkg holds:
  - State encoding: IDLE, WAIT_EOL, TIME_DIG, TIME_EOL, FLUSH.
  - ASCII constants: LF, CR, '0', '9', 'S', 'R', 'C', 'T' and the lowercase offset 0x20.
  - Range limits: 23 and 59.
- One sub-module, bcd_pair_to_bin: two 4-bit digits -> 7-bit value plus an in-range flag against a max input. Instantiated three times.

Test Plan:
- Bytes "S\n" -> o_send_req high for exactly one cycle, one cycle after the '\n' rx_done; all other pulses stay 0.
- Bytes "t123456\r\n" -> o_set_time pulse with o_set_hour=12, o_set_min=34, o_set_sec=56.
- Bytes "T245959\n" -> o_cmd_err pulse, no o_set_time, o_set_* keep previous values 12/34/56.
- Bytes "X\nR\n" -> one o_cmd_err after 'X', then o_run_toggle after the second '\n'.
- Bytes "T12a4\nC\n" -> one o_cmd_err after 'a', flush until the '\n', then o_clear.
- Sequence "T12", then reset asserted for 3 cycles, then "C\n" -> no pulses during reset, o_busy=0 after reset, o_clear pulses once.
- With CMD_TIMEOUT_EN and TIMEOUT_CYC=100: "T1", then 100 idle cycles -> o_cmd_err pulse and o_busy falls; then "S\n" -> o_send_req.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Purpose  : Shared types and constants for the UART ASCII command decoder:
//            parser state encoding, latched command codes, ASCII byte
//            constants, time range limits and a case-folding helper.
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_EOL = 3'd1,
        ST_TIME_DIG = 3'd2,
        ST_TIME_EOL = 3'd3,
        ST_FLUSH    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_SEND  = 2'd1,
        CMD_RUN   = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_e;

    localparam logic [7:0] c_ASCII_LF      = 8'h0A;
    localparam logic [7:0] c_ASCII_CR      = 8'h0D;
    localparam logic [7:0] c_ASCII_ZERO    = 8'h30;
    localparam logic [7:0] c_ASCII_NINE    = 8'h39;
    localparam logic [7:0] c_ASCII_S       = 8'h53;
    localparam logic [7:0] c_ASCII_R       = 8'h52;
    localparam logic [7:0] c_ASCII_C       = 8'h43;
    localparam logic [7:0] c_ASCII_T       = 8'h54;
    localparam logic [7:0] c_ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] c_ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] c_LOWER_OFFSET  = 8'h20;

    localparam logic [6:0] c_MAX_HOUR      = 7'd23;
    localparam logic [6:0] c_MAX_MIN_SEC   = 7'd59;

    // Folds 'a'..'z' onto 'A'..'Z'; every other byte passes unchanged.
    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (b >= c_ASCII_LOWER_A && b <= c_ASCII_LOWER_Z)
            return b - c_LOWER_OFFSET;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decoder_if
// Purpose  : Groups the receive byte stream and the decoded control outputs
//            of the UART command decoder.
// Ports    : rx_done/rx_data (byte strobe + data), o_send_req, o_run_toggle,
//            o_clear, o_set_time, o_set_hour/min/sec, o_cmd_err, o_busy.
//            master = byte source / output consumer, slave = decoder.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_decoder_if;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       o_send_req;
    logic       o_run_toggle;
    logic       o_clear;
    logic       o_set_time;
    logic [5:0] o_set_hour;
    logic [5:0] o_set_min;
    logic [5:0] o_set_sec;
    logic       o_cmd_err;
    logic       o_busy;

    modport master (
        output rx_done, rx_data,
        input  o_send_req, o_run_toggle, o_clear, o_set_time,
               o_set_hour, o_set_min, o_set_sec, o_cmd_err, o_busy
    );

    modport slave (
        input  rx_done, rx_data,
        output o_send_req, o_run_toggle, o_clear, o_set_time,
               o_set_hour, o_set_min, o_set_sec, o_cmd_err, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/bcd_pair_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pair_to_bin
// Purpose  : Converts a two-digit decimal pair to binary and flags whether
//            the result does not exceed a supplied maximum.
// Ports    : i_tens, i_ones (4-bit digits), i_max (7-bit limit),
//            o_value (7-bit tens*10+ones), o_in_range (o_value <= i_max).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_pair_to_bin (
    input  wire logic [3:0] i_tens,
    input  wire logic [3:0] i_ones,
    input  wire logic [6:0] i_max,
    output logic      [6:0] o_value,
    output logic            o_in_range
);
    // Digits are 0..9 so the result never exceeds 99 and fits in 7 bits.
    assign o_value    = (7'(i_tens) * 7'd10) + 7'(i_ones);
    assign o_in_range = (o_value <= i_max);
endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decoder
// Purpose  : Line-based ASCII command parser on the UART receive stream.
//            S/R/C + LF pulse send/run/clear; THHMMSS + LF loads a validated
//            time. Malformed lines pulse o_cmd_err and are flushed to LF.
// Ports    : clk, reset (async, active-high), bus (uart_cmd_decoder_if.slave).
// Options  : CMD_TIMEOUT_EN - abort a stalled command after TIMEOUT_CYC idle
//            cycles (TIMEOUT_CYC unused otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input wire logic          clk,
    input wire logic          reset,
    uart_cmd_decoder_if.slave bus
);
    state_e          r_state, w_state_nxt;
    cmd_e            r_cmd, w_cmd_nxt;
    logic [5:0][3:0] r_dig, w_dig_nxt;
    logic [2:0]      r_cnt, w_cnt_nxt;
    logic            r_send, w_send_nxt;
    logic            r_run, w_run_nxt;
    logic            r_clr, w_clr_nxt;
    logic            r_set, w_set_nxt;
    logic            r_err, w_err_nxt;
    logic            r_busy;
    logic [5:0]      r_hour, w_hour_nxt;
    logic [5:0]      r_min, w_min_nxt;
    logic [5:0]      r_sec, w_sec_nxt;

    logic [7:0]      w_byte;
    logic            w_is_digit;
    logic            w_is_lf;
    logic            w_timeout;
    logic [6:0]      w_hour_val, w_min_val, w_sec_val;
    logic            w_hour_ok, w_min_ok, w_sec_ok;

    assign w_byte     = to_upper(bus.rx_data);
    assign w_is_digit = (w_byte >= c_ASCII_ZERO) && (w_byte <= c_ASCII_NINE);
    assign w_is_lf    = (w_byte == c_ASCII_LF);

    bcd_pair_to_bin u_hour (.i_tens(r_dig[0]), .i_ones(r_dig[1]), .i_max(c_MAX_HOUR),
                            .o_value(w_hour_val), .o_in_range(w_hour_ok));
    bcd_pair_to_bin u_min  (.i_tens(r_dig[2]), .i_ones(r_dig[3]), .i_max(c_MAX_MIN_SEC),
                            .o_value(w_min_val), .o_in_range(w_min_ok));
    bcd_pair_to_bin u_sec  (.i_tens(r_dig[4]), .i_ones(r_dig[5]), .i_max(c_MAX_MIN_SEC),
                            .o_value(w_sec_val), .o_in_range(w_sec_ok));

`ifdef CMD_TIMEOUT_EN
    logic [31:0] r_to_cnt;

    // A byte arriving in the expiry cycle wins over the timeout.
    assign w_timeout = (r_state != ST_IDLE) && !bus.rx_done &&
                       (r_to_cnt == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_to_cnt <= '0;
        else if (bus.rx_done || r_state == ST_IDLE)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 32'd1;
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^32'(TIMEOUT_CYC);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_dig_nxt   = r_dig;
        w_cnt_nxt   = r_cnt;
        w_send_nxt  = 1'b0;
        w_run_nxt   = 1'b0;
        w_clr_nxt   = 1'b0;
        w_set_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_hour_nxt  = r_hour;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;

        if (bus.rx_done && w_byte != c_ASCII_CR) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_byte == c_ASCII_S) begin
                        w_cmd_nxt   = CMD_SEND;
                        w_state_nxt = ST_WAIT_EOL;
                    end else if (w_byte == c_ASCII_R) begin
                        w_cmd_nxt   = CMD_RUN;
                        w_state_nxt = ST_WAIT_EOL;
                    end else if (w_byte == c_ASCII_C) begin
                        w_cmd_nxt   = CMD_CLEAR;
                        w_state_nxt = ST_WAIT_EOL;
                    end else if (w_byte == c_ASCII_T) begin
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = ST_TIME_DIG;
                    end else if (!w_is_lf) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end
                ST_WAIT_EOL: begin
                    if (w_is_lf) begin
                        w_send_nxt  = (r_cmd == CMD_SEND);
                        w_run_nxt   = (r_cmd == CMD_RUN);
                        w_clr_nxt   = (r_cmd == CMD_CLEAR);
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end
                ST_TIME_DIG: begin
                    if (w_is_digit) begin
                        w_dig_nxt[r_cnt] = w_byte[3:0];
                        w_cnt_nxt        = r_cnt + 3'd1;
                        if (r_cnt == 3'd5)
                            w_state_nxt = ST_TIME_EOL;
                    end else if (w_is_lf) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end
                ST_TIME_EOL: begin
                    if (w_is_lf) begin
                        if (w_hour_ok && w_min_ok && w_sec_ok) begin
                            w_hour_nxt = w_hour_val[5:0];
                            w_min_nxt  = w_min_val[5:0];
                            w_sec_nxt  = w_sec_val[5:0];
                            w_set_nxt  = 1'b1;
                        end else begin
                            w_err_nxt  = 1'b1;
                        end
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_is_lf)
                        w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            // An abandoned flush is not a new error; anything else is.
            w_err_nxt   = (r_state != ST_FLUSH);
            w_dig_nxt   = '0;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= CMD_NONE;
            r_dig   <= '0;
            r_cnt   <= 3'd0;
            r_send  <= 1'b0;
            r_run   <= 1'b0;
            r_clr   <= 1'b0;
            r_set   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_hour  <= 6'd0;
            r_min   <= 6'd0;
            r_sec   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            r_dig   <= w_dig_nxt;
            r_cnt   <= w_cnt_nxt;
            r_send  <= w_send_nxt;
            r_run   <= w_run_nxt;
            r_clr   <= w_clr_nxt;
            r_set   <= w_set_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_hour  <= w_hour_nxt;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
        end
    end

    assign bus.o_send_req   = r_send;
    assign bus.o_run_toggle = r_run;
    assign bus.o_clear      = r_clr;
    assign bus.o_set_time   = r_set;
    assign bus.o_set_hour   = r_hour;
    assign bus.o_set_min    = r_min;
    assign bus.o_set_sec    = r_sec;
    assign bus.o_cmd_err    = r_err;
    assign bus.o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_decoder
// Purpose  : Scoreboard bench for uart_cmd_decoder. Directed byte sequences
//            queue the expected pulse (with its cycle and set values); a
//            negedge monitor pops and compares whenever any pulse is high.
// Options  : CMD_TIMEOUT_EN enables the stalled-command scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

    localparam logic [4:0] P_SEND = 5'b10000;
    localparam logic [4:0] P_RUN  = 5'b01000;
    localparam logic [4:0] P_CLR  = 5'b00100;
    localparam logic [4:0] P_SET  = 5'b00010;
    localparam logic [4:0] P_ERR  = 5'b00001;

    typedef struct {
        logic [4:0] pulses;
        int         edge_no;
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(.TIMEOUT_CYC(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         edge_n   = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       q[$];
    logic [5:0] m_h = 6'd0, m_m = 6'd0, m_s = 6'd0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic push(input logic [4:0] p, input int e);
        exp_t x;
        x.pulses = p; x.edge_no = e; x.h = m_h; x.m = m_m; x.s = m_s;
        q.push_back(x);
    endtask

    // One byte per clock; consecutive calls yield back-to-back rx_done.
    task automatic send(input logic [7:0] b, input logic [4:0] p);
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        @(posedge clk);
        #1;
        bus.rx_done = 1'b0;
        if (p != 5'b0) push(p, edge_n);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 5'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [4:0] w;
        exp_t       x;
        w = {bus.o_send_req, bus.o_run_toggle, bus.o_clear, bus.o_set_time, bus.o_cmd_err};
        if (w != 5'b0) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got pulses %b at edge %0d, none expected", w, edge_n);
            end else begin
                x = q.pop_front();
                if (w !== x.pulses || edge_n != x.edge_no || bus.o_set_hour !== x.h ||
                    bus.o_set_min !== x.m || bus.o_set_sec !== x.s) begin
                    n_fail++;
                    $display("FAIL pulse_event: got pulses %b edge %0d time %0d:%0d:%0d, expected pulses %b edge %0d time %0d:%0d:%0d",
                             w, edge_n, bus.o_set_hour, bus.o_set_min, bus.o_set_sec,
                             x.pulses, x.edge_no, x.h, x.m, x.s);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        idle(3);
        check("reset_busy",    int'(bus.o_busy), 0);
        check("reset_hour",    int'(bus.o_set_hour), 0);
        check("reset_min",     int'(bus.o_set_min), 0);
        check("reset_sec",     int'(bus.o_set_sec), 0);
        check("reset_pulses",  int'({bus.o_send_req, bus.o_run_toggle, bus.o_clear,
                                     bus.o_set_time, bus.o_cmd_err}), 0);
        reset = 1'b0;
        idle(2);

        // "S\n" -> send request
        send("S", 5'b0);
        check("busy_after_S", int'(bus.o_busy), 1);
        send(8'h0A, P_SEND);
        idle(3);
        check("idle_after_S", int'(bus.o_busy), 0);

        // "t123456\r\n" -> set 12:34:56
        send_str("t123456\r");
        check("busy_time_eol", int'(bus.o_busy), 1);
        m_h = 6'd12; m_m = 6'd34; m_s = 6'd56;
        send(8'h0A, P_SET);
        idle(2);

        // "T245959\n" -> hour out of range, values held
        send_str("T245959");
        send(8'h0A, P_ERR);
        idle(2);

        // "X\nR\n" -> error, then run toggle (back-to-back bytes)
        send("X", P_ERR);
        send(8'h0A, 5'b0);
        send("R", 5'b0);
        send(8'h0A, P_RUN);
        idle(2);

        // "T12a4\nC\n" -> error at 'a', flush, then clear
        send_str("T12");
        send("a", P_ERR);
        send_str("4\nC");
        send(8'h0A, P_CLR);
        idle(2);

        // "T12", reset mid-command, then "C\n"
        send_str("T12");
        check("busy_mid_T12", int'(bus.o_busy), 1);
        reset = 1'b1;
        idle(3);
        check("busy_in_reset", int'(bus.o_busy), 0);
        check("hour_in_reset", int'(bus.o_set_hour), 0);
        m_h = 6'd0; m_m = 6'd0; m_s = 6'd0;
        reset = 1'b0;
        idle(2);
        check("busy_after_reset", int'(bus.o_busy), 0);
        send("C", 5'b0);
        send(8'h0A, P_CLR);
        idle(2);

`ifdef CMD_TIMEOUT_EN
        // "T1" then 100 idle cycles -> timeout error, then "S\n"
        send("T", 5'b0);
        send("1", 5'b0);
        push(P_ERR, edge_n + 100);
        idle(101);
        check("busy_after_timeout", int'(bus.o_busy), 0);
        send("S", 5'b0);
        send(8'h0A, P_SEND);
        idle(2);
`endif

        idle(5);
        check("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
